audio_voice_mixer: RTL

Downstream stage of the synth voice generators: snapshots the signed sample outputs of NUM_VOICES voices on each rising edge of `sample_clock`. It scales each sample by a per-voice volume, sums the scaled samples with saturation to one BITDEPTH-bit mix sample, and drives a first-order pulse-density-modulated bit for the external RC/amp output. Runs entirely in the `clk` (8 MHz) domain. `sample_clock` is treated as a slow level input and edge-detected internally.

---
 rtl/audio_voice_mixer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer
//
// Snapshots NUM_VOICES signed voice samples on each rising edge of sample_clock,
// scales each by an unsigned per-voice volume (255 ~ unity), sums them one voice
// per clk, then floors and saturates the result to a BITDEPTH-bit signed mix.
// A first-order sigma-delta modulator turns the held mix into a 1-bit stream.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   sample_clock  slow level input; a low->high transition starts one mix
//   voice_in      packed signed voice samples, voice i at [i*BITDEPTH +: BITDEPTH]
//   volume        packed unsigned volumes, voice i at [i*VOLUME_BITS +: VOLUME_BITS]
//   clip_clear    single-cycle pulse clearing the sticky clip flag
//   mix_out       saturated signed mix, held between updates
//   mix_valid     one-cycle pulse when mix_out updates
//   clip          sticky flag, set when a mix saturates
//   pdm_out       pulse-density bitstream of mix_out
module audio_voice_mixer #(
    parameter int BITDEPTH    = 14,
    parameter int NUM_VOICES  = 4,
    parameter int VOLUME_BITS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_clock,
    input  logic [NUM_VOICES*BITDEPTH-1:0]    voice_in,
    input  logic [NUM_VOICES*VOLUME_BITS-1:0] volume,
    input  logic                              clip_clear,
    output logic [BITDEPTH-1:0]               mix_out,
    output logic                              mix_valid,
    output logic                              clip,
    output logic                              pdm_out
);

    localparam int PROD_W = BITDEPTH + VOLUME_BITS;
    localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'(2 ** (BITDEPTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIX_MIN = ~MIX_MAX;

    logic [1:0]                        state_q, state_d;
    logic                              sc_prev_q;
    logic [NUM_VOICES*BITDEPTH-1:0]    voice_snap_q, voice_snap_d;
    logic [NUM_VOICES*VOLUME_BITS-1:0] vol_snap_q, vol_snap_d;
    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [BITDEPTH-1:0]               mix_q, mix_d;
    logic                              valid_q, valid_d;
    logic                              clip_q, clip_d;
    logic [BITDEPTH:0]                 pdm_acc_q, pdm_acc_d;

    logic                              start;
    logic [BITDEPTH-1:0]               cur_voice;
    logic [VOLUME_BITS-1:0]            cur_vol;
    logic signed [PROD_W-1:0]          voice_ext, vol_ext, product;
    logic signed [ACC_W-1:0]           shifted;
    logic [BITDEPTH-1:0]               pdm_u;

    assign start = sample_clock & ~sc_prev_q;

    // Select the snapshot entry addressed by idx.
    always_comb begin
        cur_voice = '0;
        cur_vol   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_voice = voice_snap_q[i*BITDEPTH +: BITDEPTH];
                cur_vol   = vol_snap_q[i*VOLUME_BITS +: VOLUME_BITS];
            end
        end
    end

    // Volume is unsigned, so it is zero-extended before the signed multiply.
    // The true product always fits in PROD_W signed bits.
    always_comb begin
        voice_ext = PROD_W'($signed(cur_voice));
        vol_ext   = PROD_W'({1'b0, cur_vol});
        product   = voice_ext * vol_ext;
    end

    assign shifted = acc_q >>> VOLUME_BITS;

    // Offset-binary view of the mix: flip the sign bit.
    assign pdm_u = {~mix_q[BITDEPTH-1], mix_q[BITDEPTH-2:0]};

    always_comb begin
        state_d      = state_q;
        voice_snap_d = voice_snap_q;
        vol_snap_d   = vol_snap_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        mix_d        = mix_q;
        valid_d      = 1'b0;
        clip_d       = clip_q;

        if (clip_clear) begin
            clip_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    voice_snap_d = voice_in;
                    vol_snap_d   = volume;
                    acc_d        = '0;
                    idx_d        = '0;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(product);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
                // A saturation overrides a same-cycle clip_clear.
                if (shifted > MIX_MAX) begin
                    mix_d  = MIX_MAX[BITDEPTH-1:0];
                    clip_d = 1'b1;
                end else if (shifted < MIX_MIN) begin
                    mix_d  = MIX_MIN[BITDEPTH-1:0];
                    clip_d = 1'b1;
                end else begin
                    mix_d = shifted[BITDEPTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Carry out of the low BITDEPTH bits is the output bit; it is dropped
    // before the next add so the accumulator never grows.
    assign pdm_acc_d = {1'b0, pdm_acc_q[BITDEPTH-1:0]} + {1'b0, pdm_u};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sc_prev_q    <= 1'b1;  // a level already high at release is not an edge
            voice_snap_q <= '0;
            vol_snap_q   <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            mix_q        <= '0;
            valid_q      <= 1'b0;
            clip_q       <= 1'b0;
            pdm_acc_q    <= '0;
        end else begin
            state_q      <= state_d;
            sc_prev_q    <= sample_clock;
            voice_snap_q <= voice_snap_d;
            vol_snap_q   <= vol_snap_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            mix_q        <= mix_d;
            valid_q      <= valid_d;
            clip_q       <= clip_d;
            pdm_acc_q    <= pdm_acc_d;
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = valid_q;
    assign clip      = clip_q;
    assign pdm_out   = pdm_acc_q[BITDEPTH];

endmodule
